register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised successor to the single-write register file: configurable width and depth, two write ports, and optional write-to-read bypass.
- Adds a multi-cycle bulk-clear sequencer (Clear_start / Busy / Clear_done) so the core can re-initialise architectural state without a full reset.
- Sits between decode (read ports) and the WB and late-load stages (write ports A/B).

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; NUM_REGS = 2**ADDR_W.
- SP_IDX, 2: index of the stack-pointer register.
- SP_INIT, 2047: value loaded into SP_IDX on reset and on clear (truncated to DATA_W).
- BYPASS, 1: 1 = a same-cycle write is visible on the read ports; 0 = read-after-edge only.

Ports:
- Clock  in  1  single clock, all state updates on posedge.
- Reset_n  in  1  synchronous, active-high reset (despite the name); sampled on posedge Clock.
- Read_addr1  in  ADDR_W  read port 1 address.
- Read_addr2  in  ADDR_W  read port 2 address.
- Read_data1  out  DATA_W  read port 1 data (combinational).
- Read_data2  out  DATA_W  read port 2 data (combinational).
- Write_addr_a  in  ADDR_W  write port A address (WB).
- Write_En_a  in  1  write port A enable.
- Write_data_a  in  DATA_W  write port A data.
- Write_addr_b  in  ADDR_W  write port B address (late load).
- Write_En_b  in  1  write port B enable.
- Write_data_b  in  DATA_W  write port B data.
- Clear_start  in  1  one-cycle request to start a bulk clear.
- Busy  out  1  high while the clear sequence runs.
- Clear_done  out  1  one-cycle pulse when the clear completes.
- Write_drop  out  1  combinational; = Busy & (Write_En_a | Write_En_b).

Behaviour:
- Reset (Reset_n=1 at posedge) has priority over everything:
  - all registers <= 0, except registers[SP_IDX] <= SP_INIT;
  - FSM -> IDLE, clear index <= 1, Clear_done <= 0;
  - writes and Clear_start in the same cycle are ignored.
- Reset output values: Busy=0, Clear_done=0. Read data reflects the initialised array (reg 0 = 0, SP = SP_INIT).
- Register 0:
  - always reads 0, including under bypass;
  - writes to address 0 are discarded.
- Writes (IDLE only): take effect at posedge; 1-cycle latency to read when BYPASS=0.
  - If Write_addr_a == Write_addr_b and both enables are set, port B wins.
  - Different addresses: both written in the same cycle.
- Reads:
  - Combinational from the array.
  - If BYPASS=1 and not Busy: read address equals an enabled write address (nonzero) -> return that write data, with port B taking priority over A.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on Clear_start=1. Index <= 1; no array write occurs on the start edge.
  - In CLEAR, each cycle: registers[idx] <= (idx==SP_IDX) ? SP_INIT : 0, then idx <= idx+1.
  - On the edge that writes idx == NUM_REGS-1: state <= IDLE, Clear_done <= 1 (high for exactly the next cycle).
  - Clear takes NUM_REGS-1 cycles in CLEAR; Busy is high for exactly those cycles.
  - Clear_start while in CLEAR is ignored (no restart, no queueing).
  - Clear_start in the cycle Clear_done is high starts a new clear normally.
- During CLEAR:
  - all write enables are ignored and Write_drop reflects them;
  - bypass is disabled;
  - reads return current array contents, so registers may be partially cleared.
- Index counter is ADDR_W bits; it never wraps, because the FSM exits at NUM_REGS-1.
- Reset mid-clear aborts the sequence:
  - Busy=0 the next cycle;
  - no Clear_done pulse;
  - array fully initialised.

Test Plan:
- Reset for 1 cycle -> Read_addr1=2 gives 2047, Read_addr2=5 gives 0, Busy=0, Clear_done=0.
- Write_En_a=Write_En_b=1, both addr 7, data_a=0x11, data_b=0x22 -> after the edge, reg 7 = 0x22. Write addr 0 = 0xFF -> reads 0.
- BYPASS=1: write addr 9 = 0xABCD with Read_addr1=9 in the same cycle -> Read_data1=0xABCD before the edge. With BYPASS=0 -> old value until after the edge.
- Preload regs 1..31 with idx+100, pulse Clear_start ->
  - Busy high for exactly 31 cycles, Clear_done high for 1 cycle after;
  - all regs 0 except reg 2 = 2047.
- Mid-clear (cycle 10): Write_En_a=1 to addr 20 -> Write_drop=1, reg 20 ends at 0. A second Clear_start is ignored: Busy still totals 31 cycles.
- Reset asserted at clear cycle 5 -> next cycle Busy=0, no Clear_done, all regs init. A subsequent write to addr 30 works normally.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports, two combinational read ports,
// optional write-to-read bypass and a multi-cycle bulk-clear sequencer.
module register_file_mp #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned SP_IDX  = 2,
  parameter int unsigned SP_INIT = 2047,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Read_addr1,
  input  logic [ADDR_W-1:0] Read_addr2,
  output logic [DATA_W-1:0] Read_data1,
  output logic [DATA_W-1:0] Read_data2,
  input  logic [ADDR_W-1:0] Write_addr_a,
  input  logic              Write_En_a,
  input  logic [DATA_W-1:0] Write_data_a,
  input  logic [ADDR_W-1:0] Write_addr_b,
  input  logic              Write_En_b,
  input  logic [DATA_W-1:0] Write_data_b,
  input  logic              Clear_start,
  output logic              Busy,
  output logic              Clear_done,
  output logic              Write_drop
);

  localparam int unsigned       NUM_REGS = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_INIT);
  localparam logic [ADDR_W-1:0] SP_ADDR  = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              clear_done_q, clear_done_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              bypass_en;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign Busy       = (state_q == S_CLEAR);
  assign Clear_done = clear_done_q;
  assign Write_drop = Busy & (Write_En_a | Write_En_b);

  // Next-state: port writes while idle, one register per cycle while clearing
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    clear_done_d = 1'b0;
    regs_d       = regs_q;
    case (state_q)
      S_IDLE: begin
        if (Write_En_a && (Write_addr_a != '0)) regs_d[Write_addr_a] = Write_data_a;
        // B is applied second so it wins an address collision
        if (Write_En_b && (Write_addr_b != '0)) regs_d[Write_addr_b] = Write_data_b;
        if (Clear_start) begin
          state_d = S_CLEAR;
          idx_d   = ADDR_W'(1);
        end
      end
      S_CLEAR: begin
        regs_d[idx_q] = (idx_q == SP_ADDR) ? SP_VAL : '0;
        idx_d         = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d      = S_IDLE;
          idx_d        = idx_q;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and array registers; Reset_n is an active-high synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= ADDR_W'(1);
      clear_done_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_VAL : '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      clear_done_q <= clear_done_d;
      regs_q       <= regs_d;
    end
  end

  assign bypass_en  = BYPASS & ~Busy;
  assign rd_addr[0] = Read_addr1;
  assign rd_addr[1] = Read_addr2;
  assign Read_data1 = rd_data[0];
  assign Read_data2 = rd_data[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    // Read mux: array value, overridden by a same-cycle write when bypassing
    always_comb begin
      rd_data[p] = regs_q[rd_addr[p]];
      if (bypass_en) begin
        if (Write_En_a && (Write_addr_a == rd_addr[p])) rd_data[p] = Write_data_a;
        if (Write_En_b && (Write_addr_b == rd_addr[p])) rd_data[p] = Write_data_b;
      end
      if (rd_addr[p] == '0) rd_data[p] = '0;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomized bench for register_file_mp against an array reference model;
// a second instance with the bypass disabled is checked alongside.
module tb_register_file_mp;

  localparam int          NR  = 32;
  localparam int          SPI = 2;
  localparam logic [31:0] SPV = 32'd2047;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, wa, wb;
  logic        ena, enb, cs;
  logic [31:0] da, db;
  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        busy, done, drop, nb_busy, nb_done, nb_drop;

  logic [31:0] m [NR];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  register_file_mp u_dut (
    .Clock(clk), .Reset_n(rst), .Read_addr1(ra1), .Read_addr2(ra2),
    .Read_data1(rd1), .Read_data2(rd2),
    .Write_addr_a(wa), .Write_En_a(ena), .Write_data_a(da),
    .Write_addr_b(wb), .Write_En_b(enb), .Write_data_b(db),
    .Clear_start(cs), .Busy(busy), .Clear_done(done), .Write_drop(drop)
  );

  register_file_mp #(.BYPASS(1'b0)) u_dut_nb (
    .Clock(clk), .Reset_n(rst), .Read_addr1(ra1), .Read_addr2(ra2),
    .Read_data1(nb_rd1), .Read_data2(nb_rd2),
    .Write_addr_a(wa), .Write_En_a(ena), .Write_data_a(da),
    .Write_addr_b(wb), .Write_En_b(enb), .Write_data_b(db),
    .Clear_start(cs), .Busy(nb_busy), .Clear_done(nb_done), .Write_drop(nb_drop)
  );

  task automatic model_init();
    for (int i = 0; i < NR; i++) m[i] = (i == SPI) ? SPV : 32'd0;
  endtask

  task automatic idle_inputs();
    ena = 1'b0; enb = 1'b0; cs = 1'b0;
    wa = '0; wb = '0; da = '0; db = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write();
    if (ena && wa != 5'd0) m[wa] = da;
    if (enb && wb != 5'd0) m[wb] = db;
  endtask

  // Expected read with bypass: reg 0 is zero, then B, then A, then the array
  function automatic logic [31:0] exp_byp(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (enb && wb == a) return db;
    if (ena && wa == a) return da;
    return m[a];
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    ra1 = 5'd0; ra2 = 5'd0;
    tick();
    rst = 1'b0;
    model_init();
    ra1 = 5'd2; ra2 = 5'd5;
    #1;
    n_cmp++; if (rd1 !== SPV) begin n_bad++; $display("FAIL reset_sp: got %0d want %0d", rd1, SPV); end
    n_cmp++; if (rd2 !== 32'd0) begin n_bad++; $display("FAIL reset_r5: got %0d want 0", rd2); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (nb_rd1 !== SPV) begin n_bad++; $display("FAIL reset_nb_sp: got %0d want %0d", nb_rd1, SPV); end
  endtask

  task automatic test_dual_write();
    ena = 1'b1; enb = 1'b1; wa = 5'd7; wb = 5'd7; da = 32'h11; db = 32'h22;
    ra1 = 5'd7; ra2 = 5'd7;
    #1;
    n_cmp++; if (rd1 !== 32'h22) begin n_bad++; $display("FAIL collide_bypass: got %0h want 22", rd1); end
    n_cmp++; if (nb_rd1 !== m[7]) begin n_bad++; $display("FAIL collide_nb_old: got %0h want %0h", nb_rd1, m[7]); end
    n_cmp++; if (drop !== 1'b0) begin n_bad++; $display("FAIL idle_drop: got %b want 0", drop); end
    tick();
    model_write();
    idle_inputs();
    #1;
    n_cmp++; if (rd1 !== 32'h22) begin n_bad++; $display("FAIL collide_after: got %0h want 22", rd1); end
    n_cmp++; if (nb_rd2 !== 32'h22) begin n_bad++; $display("FAIL collide_nb_after: got %0h want 22", nb_rd2); end
    ena = 1'b1; enb = 1'b1; wa = 5'd0; wb = 5'd0; da = 32'hFF; db = 32'hFF;
    ra1 = 5'd0; ra2 = 5'd0;
    #1;
    n_cmp++; if (rd1 !== 32'd0) begin n_bad++; $display("FAIL r0_bypass: got %0h want 0", rd1); end
    tick();
    model_write();
    idle_inputs();
    #1;
    n_cmp++; if (rd2 !== 32'd0) begin n_bad++; $display("FAIL r0_after: got %0h want 0", rd2); end
    n_cmp++; if (nb_rd1 !== 32'd0) begin n_bad++; $display("FAIL r0_nb_after: got %0h want 0", nb_rd1); end
  endtask

  task automatic test_bypass();
    ena = 1'b1; wa = 5'd9; da = 32'hABCD; ra1 = 5'd9; ra2 = 5'd9;
    #1;
    n_cmp++; if (rd1 !== 32'hABCD) begin n_bad++; $display("FAIL bypass_same_cycle: got %0h want abcd", rd1); end
    n_cmp++; if (nb_rd1 !== m[9]) begin n_bad++; $display("FAIL nobypass_old: got %0h want %0h", nb_rd1, m[9]); end
    tick();
    model_write();
    idle_inputs();
    #1;
    n_cmp++; if (nb_rd1 !== 32'hABCD) begin n_bad++; $display("FAIL nobypass_after: got %0h want abcd", nb_rd1); end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int n = 0; n < 300; n++) begin
      ena = 1'($urandom_range(0, 1));
      enb = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, NR - 1));
      wb  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, NR - 1));
      da  = $urandom();
      db  = $urandom();
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, NR - 1));
      ra2 = ($urandom_range(0, 2) == 0) ? wb : 5'($urandom_range(0, NR - 1));
      #1;
      e = exp_byp(ra1);
      n_cmp++; if (rd1 !== e) begin n_bad++; $display("FAIL rand_rd1 a=%0d: got %0h want %0h", ra1, rd1, e); end
      e = exp_byp(ra2);
      n_cmp++; if (rd2 !== e) begin n_bad++; $display("FAIL rand_rd2 a=%0d: got %0h want %0h", ra2, rd2, e); end
      n_cmp++; if (nb_rd1 !== m[ra1]) begin n_bad++; $display("FAIL rand_nb_rd1 a=%0d: got %0h want %0h", ra1, nb_rd1, m[ra1]); end
      n_cmp++; if (nb_rd2 !== m[ra2]) begin n_bad++; $display("FAIL rand_nb_rd2 a=%0d: got %0h want %0h", ra2, nb_rd2, m[ra2]); end
      tick();
      model_write();
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cnt;
    for (int i = 1; i < NR; i++) begin
      ena = 1'b1; wa = 5'(i); da = 32'(i + 100);
      tick();
      model_write();
    end
    idle_inputs();
    cs = 1'b1;
    tick();
    cs = 1'b0;
    // busy cycles 1..31; cycle k clears register k on its closing edge
    for (int c = 1; c <= NR - 1; c++) begin
      n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL clear_busy c=%0d: got busy=%b done=%b want 1/0", c, busy, done); end
      if (c == 10) begin
        ena = 1'b1; wa = 5'd20; da = 32'hDEAD; ra1 = 5'd20; ra2 = 5'd5;
        #1;
        n_cmp++; if (drop !== 1'b1) begin n_bad++; $display("FAIL clear_drop: got %b want 1", drop); end
        n_cmp++; if (rd1 !== 32'd120) begin n_bad++; $display("FAIL clear_no_bypass: got %0h want %0h", rd1, 32'd120); end
        n_cmp++; if (rd2 !== 32'd0) begin n_bad++; $display("FAIL clear_partial: got %0h want 0", rd2); end
      end
      if (c == 15) cs = 1'b1;
      tick();
      idle_inputs();
    end
    model_init();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b1) begin n_bad++; $display("FAIL clear_end: got busy=%b done=%b want 0/1", busy, done); end
    ra1 = 5'd20; ra2 = 5'd2;
    cs = 1'b1;
    #1;
    n_cmp++; if (rd1 !== 32'd0) begin n_bad++; $display("FAIL clear_r20: got %0h want 0", rd1); end
    n_cmp++; if (rd2 !== SPV) begin n_bad++; $display("FAIL clear_sp: got %0d want %0d", rd2, SPV); end
    tick();
    cs = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL restart_on_done: got busy=%b done=%b want 1/0", busy, done); end
    busy_cnt = 0;
    for (int c = 0; c < 40 && busy === 1'b1; c++) begin
      busy_cnt++;
      tick();
    end
    n_cmp++; if (busy_cnt != NR - 1) begin n_bad++; $display("FAIL restart_busy_len: got %0d want %0d", busy_cnt, NR - 1); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL restart_done: got %b want 1", done); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_width: got %b want 0", done); end
    for (int i = 0; i < NR; i++) begin
      ra1 = 5'(i); ra2 = 5'(NR - 1 - i);
      #1;
      n_cmp++; if (rd1 !== m[i]) begin n_bad++; $display("FAIL clear_array r%0d: got %0h want %0h", i, rd1, m[i]); end
      n_cmp++; if (nb_rd2 !== m[NR - 1 - i]) begin n_bad++; $display("FAIL clear_array_nb r%0d: got %0h want %0h", NR - 1 - i, nb_rd2, m[NR - 1 - i]); end
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 1; i < NR; i++) begin
      ena = 1'b1; wa = 5'(i); da = $urandom();
      tick();
      model_write();
    end
    idle_inputs();
    cs = 1'b1;
    tick();
    cs = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy c=%0d: got %b want 1", c, busy); end
      if (c == 5) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    model_init();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_off: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b want 0", done); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_quiet: got busy=%b done=%b want 0/0", busy, done); end
    for (int i = 0; i < NR; i++) begin
      ra1 = 5'(i); ra2 = 5'(NR - 1 - i);
      #1;
      n_cmp++; if (rd1 !== m[i]) begin n_bad++; $display("FAIL abort_array r%0d: got %0h want %0h", i, rd1, m[i]); end
      n_cmp++; if (rd2 !== m[NR - 1 - i]) begin n_bad++; $display("FAIL abort_array r%0d: got %0h want %0h", NR - 1 - i, rd2, m[NR - 1 - i]); end
    end
    ena = 1'b1; wa = 5'd30; da = 32'h3030_BEEF;
    tick();
    model_write();
    idle_inputs();
    ra1 = 5'd30;
    #1;
    n_cmp++; if (rd1 !== m[30]) begin n_bad++; $display("FAIL post_abort_write: got %0h want %0h", rd1, m[30]); end
    n_cmp++; if (nb_rd1 !== m[30]) begin n_bad++; $display("FAIL post_abort_write_nb: got %0h want %0h", nb_rd1, m[30]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    ra1 = '0; ra2 = '0;
    model_init();
    test_reset();
    test_dual_write();
    test_bypass();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
